// File: rtl/soc_system_pio_cmd_out.sv
// soc_system_pio_cmd_out
// Avalon-MM slave on the lightweight HPS-to-FPGA bridge. The HPS drives a
// DATA output register onto out_port and posts command words to fabric
// logic through a single-entry CMD mailbox with a valid/ready handshake.
// STATUS reports pending/done/overflow. done and overflow are cleared by
// writing 1 to their bits (write-1-to-clear).
module soc_system_pio_cmd_out #(
  parameter int                    DATA_WIDTH  = 4,
  parameter int                    CMD_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  cmd_valid,
  output logic [CMD_WIDTH-1:0]  cmd_data,
  input  logic                  cmd_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cmd_state_t;

  cmd_state_t      state;
  cmd_state_t      state_nxt;
  logic            cmd_load;
  logic            done_set;
  logic            ovf_set;
  logic            done;
  logic            overflow;
  logic            wr_en;
  logic            wr_data;
  logic            wr_cmd;
  logic            wr_status;
  logic            wr_outclr;
  logic [31:0]     rd_mux;
  logic            unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign wr_data   = wr_en & (address == 2'd0);
  assign wr_cmd    = wr_en & (address == 2'd1);
  assign wr_status = wr_en & (address == 2'd2);
  assign wr_outclr = wr_en & (address == 2'd3);

  // Write-data bits above the register widths are not stored anywhere.
  assign unused_wdata = ^writedata;

  // Pending flag is the state itself, so cmd_valid has no path from cmd_ready.
  assign cmd_valid = (state == PEND);

  // Mailbox next-state: accept a word when free or being freed, otherwise flag overflow.
  always_comb begin
    state_nxt = state;
    cmd_load  = 1'b0;
    done_set  = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_cmd) begin
          cmd_load  = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (cmd_ready) begin
          done_set = 1'b1;
          if (wr_cmd) begin
            cmd_load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (wr_cmd) begin
          ovf_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Mailbox state register; a reset mid-transfer simply drops the command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Held command word, only replaced when the mailbox accepts a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_data <= '0;
    end else if (cmd_load) begin
      cmd_data <= writedata[CMD_WIDTH-1:0];
    end
  end

  // Sticky status bits; a hardware set beats a same-cycle software clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (done_set) begin
        done <= 1'b1;
      end else if (wr_status && writedata[1]) begin
        done <= 1'b0;
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (wr_status && writedata[2]) begin
        overflow <= 1'b0;
      end
    end
  end

  // DATA register: full load at DATA, bit-clear at OUTCLR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
    end else if (wr_data) begin
      out_port <= writedata[DATA_WIDTH-1:0];
    end else if (wr_outclr) begin
      out_port <= out_port & ~writedata[DATA_WIDTH-1:0];
    end
  end

  // Read mux of current register state, zero-extended to the bus width.
  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[DATA_WIDTH-1:0] = out_port;
      2'd1:    rd_mux[CMD_WIDTH-1:0]  = cmd_data;
      2'd2:    rd_mux[2:0]            = {overflow, done, cmd_valid};
      default: rd_mux                 = '0;
    endcase
  end

  // Registered read data: latency 1, not gated by chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule
